// File: rtl/daa_dct_writer.sv
// ENTDAA sequencer: fetches each dynamic address from the DAT, collects PID/BCR/DCR, sends the address, writes the DCT entry.
// Latency: 2 cycles start->done with zero devices; at least 14 cycles per assigned device.
// Backpressure: ID bytes are taken at most one per cycle when valid; da_o is held stable until da_ready_i.
module daa_dct_writer #(
    parameter int DatAw = 7,
    parameter int DctAw = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DatAw-1:0]  dat_index_i,
    input  logic [DctAw-1:0]  dct_index_i,
    input  logic [3:0]        dev_count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        status_o,
    output logic [3:0]        assigned_count_o,
    output logic              dat_read_valid_o,
    output logic [DatAw-1:0]  dat_index_o,
    input  logic [63:0]       dat_rdata_i,
    output logic              dct_write_valid_o,
    output logic [DctAw-1:0]  dct_index_o,
    output logic [127:0]      dct_wdata_o,
    input  logic              rx_byte_valid_i,
    output logic              rx_byte_ready_o,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_nack_i,
    output logic              da_valid_o,
    input  logic              da_ready_i,
    output logic [7:0]        da_o,
    input  logic              da_resp_valid_i,
    input  logic              da_resp_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_DAT_RD,
        S_DAT_WAIT,
        S_RX_ID,
        S_SEND_DA,
        S_WAIT_RESP,
        S_DCT_WR,
        S_DONE
    } state_e;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_NO_DEV    = 2'd1;
    localparam logic [1:0] ST_ADDR_NACK = 2'd2;

    state_e             r_state;
    logic [DatAw-1:0]   r_dat_idx;
    logic [DctAw-1:0]   r_dct_idx;
    logic [3:0]         r_dev_cnt;
    logic [3:0]         r_assigned;
    logic [2:0]         r_byte_cnt;
    logic [63:0]        r_id;
    logic [6:0]         r_da;
    logic [1:0]         r_status;
    logic               r_busy;
    logic               r_done;
    logic               r_dat_rd;
    logic               r_rx_rdy;
    logic               r_da_vld;
    logic               r_dct_wr;
    logic [127:0]       r_dct_wdata;

    logic [127:0]       w_entry;
    logic               w_unused;

    // r_id holds PID[47:0] in [63:16], BCR in [15:8], DCR in [7:0] once all 8 bytes are in.
    always_comb begin
        w_entry          = '0;
        w_entry[31:0]    = r_id[63:32];
        w_entry[47:32]   = r_id[31:16];
        w_entry[71:64]   = r_id[7:0];
        w_entry[79:72]   = r_id[15:8];
        w_entry[102:96]  = r_da;
    end

    assign w_unused = ^{dat_rdata_i[63:23], dat_rdata_i[15:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_dat_idx   <= '0;
            r_dct_idx   <= '0;
            r_dev_cnt   <= '0;
            r_assigned  <= '0;
            r_byte_cnt  <= '0;
            r_id        <= '0;
            r_da        <= '0;
            r_status    <= ST_OK;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dat_rd    <= 1'b0;
            r_rx_rdy    <= 1'b0;
            r_da_vld    <= 1'b0;
            r_dct_wr    <= 1'b0;
            r_dct_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_dat_idx  <= dat_index_i;
                        r_dct_idx  <= dct_index_i;
                        r_dev_cnt  <= dev_count_i;
                        r_assigned <= '0;
                        r_status   <= ST_OK;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_assigned == r_dev_cnt) begin
                        r_status <= ST_OK;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_dat_rd <= 1'b1;
                        r_state  <= S_DAT_RD;
                    end
                end
                S_DAT_RD: begin
                    r_dat_rd <= 1'b0;
                    r_state  <= S_DAT_WAIT;
                end
                S_DAT_WAIT: begin
                    r_da       <= dat_rdata_i[22:16];
                    r_byte_cnt <= '0;
                    r_rx_rdy   <= 1'b1;
                    r_state    <= S_RX_ID;
                end
                S_RX_ID: begin
                    // A NACK beats a byte offered in the same cycle.
                    if (rx_nack_i) begin
                        r_rx_rdy <= 1'b0;
                        r_status <= ST_NO_DEV;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (rx_byte_valid_i) begin
                        r_id       <= {r_id[55:0], rx_byte_i};
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == 3'd7) begin
                            r_rx_rdy <= 1'b0;
                            r_da_vld <= 1'b1;
                            r_state  <= S_SEND_DA;
                        end
                    end
                end
                S_SEND_DA: begin
                    if (da_ready_i) begin
                        r_da_vld <= 1'b0;
                        r_state  <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (da_resp_valid_i) begin
                        if (da_resp_ack_i) begin
                            r_dct_wdata <= w_entry;
                            r_dct_wr    <= 1'b1;
                            r_state     <= S_DCT_WR;
                        end else begin
                            r_status <= ST_ADDR_NACK;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DCT_WR: begin
                    r_dct_wr   <= 1'b0;
                    r_dat_idx  <= r_dat_idx + DatAw'(1);
                    r_dct_idx  <= r_dct_idx + DctAw'(1);
                    r_assigned <= r_assigned + 4'd1;
                    r_state    <= S_CHECK;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_dat_rd <= 1'b0;
                    r_rx_rdy <= 1'b0;
                    r_da_vld <= 1'b0;
                    r_dct_wr <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign status_o          = r_status;
    assign assigned_count_o  = r_assigned;
    assign dat_read_valid_o  = r_dat_rd;
    assign dat_index_o       = r_dat_idx;
    assign dct_write_valid_o = r_dct_wr;
    assign dct_index_o       = r_dct_idx;
    assign dct_wdata_o       = r_dct_wdata;
    assign rx_byte_ready_o   = r_rx_rdy;
    assign da_valid_o        = r_da_vld;
    // Odd parity: the LSB makes the total number of ones in the byte odd.
    assign da_o              = r_da_vld ? {r_da, ~^r_da} : 8'd0;

endmodule

// File: tb/tb_daa_dct_writer.sv
// Bench for daa_dct_writer: randomized DAT/ID stimulus checked against a table-level ENTDAA model.
module tb_daa_dct_writer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [6:0]   dat_index_i;
    logic [6:0]   dct_index_i;
    logic [3:0]   dev_count_i;
    logic         busy_o;
    logic         done_o;
    logic [1:0]   status_o;
    logic [3:0]   assigned_count_o;
    logic         dat_read_valid_o;
    logic [6:0]   dat_index_o;
    logic [63:0]  dat_rdata_i;
    logic         dct_write_valid_o;
    logic [6:0]   dct_index_o;
    logic [127:0] dct_wdata_o;
    logic         rx_byte_valid_i;
    logic         rx_byte_ready_o;
    logic [7:0]   rx_byte_i;
    logic         rx_nack_i;
    logic         da_valid_o;
    logic         da_ready_i;
    logic [7:0]   da_o;
    logic         da_resp_valid_i;
    logic         da_resp_ack_i;

    always #5 clk_i = ~clk_i;

    daa_dct_writer #(.DatAw(7), .DctAw(7)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .dat_index_i(dat_index_i), .dct_index_i(dct_index_i), .dev_count_i(dev_count_i),
        .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .assigned_count_o(assigned_count_o),
        .dat_read_valid_o(dat_read_valid_o), .dat_index_o(dat_index_o), .dat_rdata_i(dat_rdata_i),
        .dct_write_valid_o(dct_write_valid_o), .dct_index_o(dct_index_o), .dct_wdata_o(dct_wdata_o),
        .rx_byte_valid_i(rx_byte_valid_i), .rx_byte_ready_o(rx_byte_ready_o), .rx_byte_i(rx_byte_i),
        .rx_nack_i(rx_nack_i), .da_valid_o(da_valid_o), .da_ready_i(da_ready_i), .da_o(da_o),
        .da_resp_valid_i(da_resp_valid_i), .da_resp_ack_i(da_resp_ack_i)
    );

    logic [63:0]  dat_mem [128];
    logic [7:0]   id_b [16][8];
    logic [134:0] wr_q[$], exp_wr_q[$];
    logic [6:0]   rd_q[$], exp_rd_q[$];
    logic [7:0]   da_q[$], exp_da_q[$];
    logic [1:0]   exp_status;
    logic [3:0]   exp_cnt;
    int           overlap = 0;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    // Table read data is valid while the DUT holds its index, i.e. in the cycle after the read strobe.
    assign dat_rdata_i = dat_mem[dat_index_o];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (dct_write_valid_o) wr_q.push_back({dct_index_o, dct_wdata_o});
        if (dat_read_valid_o)  rd_q.push_back(dat_index_o);
        if (dct_write_valid_o && dat_read_valid_o) overlap++;
    end

    task automatic fill_random();
        for (int i = 0; i < 128; i++) dat_mem[i] = {$urandom, $urandom};
        for (int d = 0; d < 16; d++)
            for (int b = 0; b < 8; b++) id_b[d][b] = 8'($urandom);
        wr_q.delete(); rd_q.delete(); da_q.delete(); overlap = 0;
    endtask

    // Expected outcome of a run, derived from the DAT contents and per-device ID bytes.
    task automatic run_model(input int d, input int c, input int n, input int nack_dev, input int anack_dev);
        logic [47:0]  pid;
        logic [6:0]   da;
        logic [127:0] e;
        int           di, ci;
        exp_wr_q.delete(); exp_rd_q.delete(); exp_da_q.delete();
        exp_status = 2'd0;
        exp_cnt    = 4'(n);
        for (int i = 0; i < n; i++) begin
            di = (d + i) % 128;
            ci = (c + i) % 128;
            exp_rd_q.push_back(7'(di));
            if (i == nack_dev) begin
                exp_status = 2'd1; exp_cnt = 4'(i); return;
            end
            da = dat_mem[di][22:16];
            exp_da_q.push_back({da, ($countones(da) % 2 == 0) ? 1'b1 : 1'b0});
            if (i == anack_dev) begin
                exp_status = 2'd2; exp_cnt = 4'(i); return;
            end
            pid = {id_b[i][0], id_b[i][1], id_b[i][2], id_b[i][3], id_b[i][4], id_b[i][5]};
            e = '0;
            e[31:0]   = pid[47:16];
            e[47:32]  = pid[15:0];
            e[71:64]  = id_b[i][7];
            e[79:72]  = id_b[i][6];
            e[102:96] = da;
            exp_wr_q.push_back({7'(ci), e});
        end
    endtask

    // Bus-engine side of one run. abort_mode 1: reset after 3 ID bytes; 2: reset during the DCT strobe.
    task automatic drive_run(input logic [6:0] d, input logic [6:0] c, input logic [3:0] n,
                             input bit stall, input bit spur, input int nack_dev, input int nack_byte,
                             input int anack_dev, input int abort_mode, output int lat, output bit tmo);
        int dev = 0, nb = 0, start_cyc;
        bit pend = 0;
        tmo = 1; lat = 0;
        @(negedge clk_i);
        start_i = 1; dat_index_i = d; dct_index_i = c; dev_count_i = n; start_cyc = cyc;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_i);
            start_i = 0; rx_byte_valid_i = 0; rx_nack_i = 0; da_ready_i = 0;
            da_resp_valid_i = 0; da_resp_ack_i = 0;
            if (done_o) begin tmo = 0; lat = cyc - start_cyc; break; end
            if ((abort_mode == 1 && rx_byte_ready_o && nb == 3) ||
                (abort_mode == 2 && dct_write_valid_o)) begin
                rst_ni = 0; tmo = 0; break;
            end
            if (spur && $urandom_range(0, 3) == 0) begin
                start_i = 1; dat_index_i = 7'($urandom); dct_index_i = 7'($urandom);
                dev_count_i = 4'($urandom);
            end
            if (rx_byte_ready_o) begin
                if (dev == nack_dev && nb == nack_byte) begin
                    rx_nack_i = 1; rx_byte_valid_i = 1; rx_byte_i = 8'($urandom);
                end else if (!stall || $urandom_range(0, 2) != 0) begin
                    rx_byte_valid_i = 1; rx_byte_i = id_b[dev][nb]; nb++;
                end
            end
            if (da_valid_o && (!stall || $urandom_range(0, 2) != 0)) begin
                da_ready_i = 1; da_q.push_back(da_o); pend = 1;
            end else if (pend && !da_valid_o && (!stall || $urandom_range(0, 1) == 0)) begin
                da_resp_valid_i = 1; da_resp_ack_i = (dev != anack_dev); pend = 0; dev++; nb = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1; #2 rst_ni = 0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({busy_o, done_o, status_o, assigned_count_o, dat_read_valid_o, dat_index_o} !== '0)
            begin bad++; $display("FAIL reset_ctrl got %h want 0", {busy_o, done_o, status_o, assigned_count_o, dat_read_valid_o, dat_index_o}); end
        total++;
        if ({dct_write_valid_o, dct_index_o, dct_wdata_o, rx_byte_ready_o, da_valid_o, da_o} !== '0)
            begin bad++; $display("FAIL reset_data got %h want 0", {dct_write_valid_o, dct_index_o, dct_wdata_o, rx_byte_ready_o, da_valid_o, da_o}); end
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        logic [7:0] vec [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hC6, 8'h44};
        logic [134:0] want = {7'd0, 128'h0000_0008_0000_C644_0000_89AB_0123_4567};
        int lat; bit tmo;
        fill_random();
        dat_mem[3][22:16] = 7'h08;
        for (int b = 0; b < 8; b++) id_b[0][b] = vec[b];
        drive_run(7'd3, 7'd0, 4'd1, 0, 0, -1, 0, -1, 0, lat, tmo);
        total++; if (tmo) begin bad++; $display("FAIL single_timeout got no done want done"); end
        total++;
        if (da_q.size() != 1 || da_q[0] !== 8'h10)
            begin bad++; $display("FAIL single_da got n=%0d %h want 10", da_q.size(), da_q.size() > 0 ? da_q[0] : 8'h0); end
        total++;
        if (wr_q.size() != 1 || wr_q[0] !== want)
            begin bad++; $display("FAIL single_wr got n=%0d %h want %h", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 135'h0, want); end
        total++;
        if (rd_q.size() != 1 || rd_q[0] !== 7'd3)
            begin bad++; $display("FAIL single_rd got n=%0d want index 3", rd_q.size()); end
        total++;
        if (status_o !== 2'd0 || assigned_count_o !== 4'd1)
            begin bad++; $display("FAIL single_status got %0d/%0d want 0/1", status_o, assigned_count_o); end
    endtask

    task automatic test_count_zero();
        @(negedge clk_i);
        start_i = 1; dev_count_i = 4'd0; dat_index_i = 7'd9; dct_index_i = 7'd9;
        @(negedge clk_i); start_i = 0;
        total++; if (busy_o !== 1'b1 || done_o !== 1'b0)
            begin bad++; $display("FAIL zero_c1 got busy=%b done=%b want 1 0", busy_o, done_o); end
        @(negedge clk_i);
        total++; if (busy_o !== 1'b1 || done_o !== 1'b1 || status_o !== 2'd0 || assigned_count_o !== 4'd0)
            begin bad++; $display("FAIL zero_c2 got busy=%b done=%b st=%0d cnt=%0d want 1 1 0 0", busy_o, done_o, status_o, assigned_count_o); end
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0 || done_o !== 1'b0)
            begin bad++; $display("FAIL zero_c3 got busy=%b done=%b want 0 0", busy_o, done_o); end
    endtask

    task automatic test_runs();
        string nm;
        int d, c, n, nd, nbt, ad, lat;
        bit st, sp, tmo;
        for (int t = 0; t < 8; t++) begin
            d = 3; c = 0; n = 3; nd = -1; nbt = 0; ad = -1; st = 1; sp = 0;
            case (t)
                0: nm = "multi_bp";
                1: begin nm = "rx_nack_b4";  nd = 1; nbt = 4; end
                2: begin nm = "rx_nack_b7";  n = 2; nd = 0; nbt = 7; end
                3: begin nm = "addr_nack";   n = 1; ad = 0; end
                4: begin nm = "wrap";        d = 126; c = 127; n = 2; end
                5: begin nm = "busy_start";  n = 2; sp = 1; end
                6: begin nm = "addr_nack_2"; n = 4; ad = 2; end
                default: begin nm = "random"; d = $urandom_range(0, 127); c = $urandom_range(0, 127); n = $urandom_range(1, 5); end
            endcase
            fill_random();
            run_model(d, c, n, nd, ad);
            drive_run(7'(d), 7'(c), 4'(n), st, sp, nd, nbt, ad, 0, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL %s_timeout got no done want done", nm); end
            total++; if (status_o !== exp_status || assigned_count_o !== exp_cnt)
                begin bad++; $display("FAIL %s_status got %0d/%0d want %0d/%0d", nm, status_o, assigned_count_o, exp_status, exp_cnt); end
            total++; if (wr_q.size() != exp_wr_q.size() || da_q.size() != exp_da_q.size() || rd_q.size() != exp_rd_q.size())
                begin bad++; $display("FAIL %s_counts got wr=%0d da=%0d rd=%0d want %0d %0d %0d", nm, wr_q.size(), da_q.size(), rd_q.size(), exp_wr_q.size(), exp_da_q.size(), exp_rd_q.size()); end
            for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
                total++; if (wr_q[i] !== exp_wr_q[i])
                    begin bad++; $display("FAIL %s_wr%0d got %h want %h", nm, i, wr_q[i], exp_wr_q[i]); end
            end
            for (int i = 0; i < da_q.size() && i < exp_da_q.size(); i++) begin
                total++; if (da_q[i] !== exp_da_q[i])
                    begin bad++; $display("FAIL %s_da%0d got %h want %h", nm, i, da_q[i], exp_da_q[i]); end
            end
            for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++) begin
                total++; if (rd_q[i] !== exp_rd_q[i])
                    begin bad++; $display("FAIL %s_rd%0d got %0d want %0d", nm, i, rd_q[i], exp_rd_q[i]); end
            end
            total++; if (overlap != 0)
                begin bad++; $display("FAIL %s_overlap got %0d want 0", nm, overlap); end
        end
    endtask

    task automatic test_reset_midrun();
        int lat; bit tmo;
        for (int m = 1; m <= 2; m++) begin
            fill_random();
            drive_run(7'd5, 7'd10, 4'd3, 0, 0, -1, 0, -1, m, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL rstmid%0d_reach got timeout want abort point", m); end
            #1;
            total++;
            if ({busy_o, done_o, status_o, assigned_count_o, dat_read_valid_o, dat_index_o, dct_write_valid_o,
                 dct_index_o, dct_wdata_o, rx_byte_ready_o, da_valid_o, da_o} !== '0)
                begin bad++; $display("FAIL rstmid%0d_outs got busy=%b wr=%b rdy=%b idx=%0d want all 0", m, busy_o, dct_write_valid_o, rx_byte_ready_o, dct_index_o); end
            wr_q.delete();
            repeat (3) @(negedge clk_i);
            rst_ni = 1;
            repeat (20) @(negedge clk_i);
            total++; if (wr_q.size() != 0 || busy_o !== 1'b0)
                begin bad++; $display("FAIL rstmid%0d_quiet got writes=%0d busy=%b want 0 0", m, wr_q.size(), busy_o); end
        end
        fill_random();
        run_model(2, 4, 2, -1, -1);
        drive_run(7'd2, 7'd4, 4'd2, 1, 0, -1, 0, -1, 0, lat, tmo);
        total++; if (tmo || status_o !== exp_status || assigned_count_o !== exp_cnt)
            begin bad++; $display("FAIL rerun_status got tmo=%b %0d/%0d want 0 %0d/%0d", tmo, status_o, assigned_count_o, exp_status, exp_cnt); end
        total++; if (wr_q.size() != exp_wr_q.size())
            begin bad++; $display("FAIL rerun_wrcount got %0d want %0d", wr_q.size(), exp_wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_wr_q[i])
                begin bad++; $display("FAIL rerun_wr%0d got %h want %h", i, wr_q[i], exp_wr_q[i]); end
        end
    endtask

    initial begin
        start_i = 0; dat_index_i = '0; dct_index_i = '0; dev_count_i = '0;
        rx_byte_valid_i = 0; rx_byte_i = '0; rx_nack_i = 0;
        da_ready_i = 0; da_resp_valid_i = 0; da_resp_ack_i = 0;
        for (int i = 0; i < 128; i++) dat_mem[i] = '0;
        test_reset();
        test_single();
        test_count_zero();
        test_runs();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
